college_grade_bank: RTL
=======================

COLLEGE_GRADE_BANK -- requirements
Module: college_grade_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 3, number of grade channels (2..16).
REQ-002 SHALL have parameter WIDTH, default 8, bits per grade value.
REQ-003 SHALL have parameter P_MASK, default 3'b100 (NUM_CH bits), channels the principal may write; bit i=1 permits channel i.
REQ-004 SHALL use CHW = max(1, clog2(NUM_CH)) for channel-index width.
REQ-005 SHALL have: clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have: rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have: t_wr_en  input  1  teacher write strobe.
REQ-008 SHALL have: t_wr_ch  input  CHW  teacher target channel.
REQ-009 SHALL have: t_wr_data  input  WIDTH  teacher write value.
REQ-010 SHALL have: p_wr_en  input  1  principal write strobe.
REQ-011 SHALL have: p_wr_ch  input  CHW  principal target channel.
REQ-012 SHALL have: p_wr_data  input  WIDTH  principal write value.
REQ-013 SHALL have: p_lock  input  1  principal finalise request; sticky.
REQ-014 SHALL have: s_rd_req  input  1  student read request.
REQ-015 SHALL have: s_rd_ch  input  CHW  student read channel.
REQ-016 SHALL have: s_rd_ready  input  1  student accepts presented data.
REQ-017 SHALL have: s_rd_valid  output  1  read data presented.
REQ-018 SHALL have: s_rd_data  output  WIDTH  read value.
REQ-019 SHALL have: s_rd_ovr  output  1  presented channel last written by principal.
REQ-020 SHALL have: locked  output  1  bank finalised.
REQ-021 SHALL have: wr_err  output  1  one-cycle pulse on any rejected write.

Function
REQ-022 SHALL hold NUM_CH registers grade[i] (WIDTH) and ovr[i] (1 bit); ovr[i] set by accepted principal write, cleared by accepted teacher write.
REQ-023 Bank FSM SHALL have states OPEN and LOCKED; OPEN->LOCKED on any edge with p_lock=1; LOCKED exits only on rst; locked=1 in LOCKED, registered (asserts cycle after p_lock).
REQ-024 Teacher write SHALL be accepted iff t_wr_en, state OPEN, t_wr_ch<NUM_CH, and not overridden by a same-cycle accepted principal write to the same channel; takes effect next edge.
REQ-025 Principal write SHALL be accepted iff p_wr_en, p_wr_ch<NUM_CH, P_MASK[p_wr_ch]=1; accepted in both OPEN and LOCKED.
REQ-026 Same cycle, same channel, both writes valid: principal wins, teacher write dropped, wr_err pulses.
REQ-027 Same cycle, different channels: both accepted.
REQ-028 wr_err SHALL pulse high exactly one cycle after any cycle containing a rejected write (out-of-range channel, non-permitted principal channel, teacher write while LOCKED, collision loss); multiple rejects in one cycle give one pulse.
REQ-029 Read FSM SHALL have states IDLE and PRESENT; IDLE with s_rd_req and s_rd_ch<NUM_CH -> PRESENT, capturing grade[s_rd_ch] and ovr[s_rd_ch] as held before that edge (same-cycle writes not visible).
REQ-030 s_rd_valid=1 in PRESENT; s_rd_data/s_rd_ovr SHALL stay stable until the edge with s_rd_ready=1, then PRESENT->IDLE; read latency 1 cycle.
REQ-031 s_rd_req in PRESENT SHALL be ignored (no queue); back-to-back reads need one IDLE cycle minimum.
REQ-032 s_rd_req with s_rd_ch>=NUM_CH SHALL be ignored; FSM stays IDLE, no error pulse.
REQ-033 s_rd_data and s_rd_ovr SHALL be 0 in IDLE.

Reset
REQ-034 rst SHALL immediately clear grade[*], ovr[*], state to OPEN and IDLE, and drive s_rd_valid, s_rd_data, s_rd_ovr, locked, wr_err to 0.
REQ-035 rst mid-read (PRESENT) SHALL drop the read; no data re-presented after release.
REQ-036 First accepted write or read SHALL be possible on the first rising edge with rst low.

Verification
REQ-037 Teacher writes ch0=85, ch1=90, ch2=95 on 3 cycles; reads each -> s_rd_data 85/90/95, s_rd_ovr=0, valid 1 cycle after req.
REQ-038 Principal writes ch2=99 then reads ch2 -> 99, s_rd_ovr=1; principal write ch0=50 -> wr_err pulse, ch0 stays 85.
REQ-039 Same cycle teacher ch2=70, principal ch2=99 -> ch2=99, ovr=1, wr_err pulse; same cycle teacher ch0=60, principal ch2=98 -> both stored, no error.
REQ-040 Read ch1 with s_rd_ready low 5 cycles while teacher writes ch1=11 -> s_rd_data holds 90 until ready; new req ignored; next read returns 11.
REQ-041 p_lock pulse -> locked=1 next cycle; teacher ch0=1 rejected with wr_err; principal ch2=77 accepted; rst -> all grades 0, locked=0.
REQ-042 Assert rst while PRESENT with valid high -> s_rd_valid=0 immediately and stays 0 after release without new req.

Source files
------------

// File: rtl/college_grade_bank.sv
// Grade bank: teacher/principal write ports with channel permissions and a
// sticky finalise lock, plus a single-entry student read port.
module college_grade_bank #(
    parameter int NUM_CH = 3,
    parameter int WIDTH = 8,
    parameter logic [NUM_CH-1:0] P_MASK = 3'b100,
    localparam int CHW = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             t_wr_en,
    input  logic [CHW-1:0]   t_wr_ch,
    input  logic [WIDTH-1:0] t_wr_data,
    input  logic             p_wr_en,
    input  logic [CHW-1:0]   p_wr_ch,
    input  logic [WIDTH-1:0] p_wr_data,
    input  logic             p_lock,
    input  logic             s_rd_req,
    input  logic [CHW-1:0]   s_rd_ch,
    input  logic             s_rd_ready,
    output logic             s_rd_valid,
    output logic [WIDTH-1:0] s_rd_data,
    output logic             s_rd_ovr,
    output logic             locked,
    output logic             wr_err
);

    typedef enum logic { OPEN, LOCKED } bank_state_t;
    typedef enum logic { IDLE, PRESENT } rd_state_t;

    bank_state_t bank_state, bank_next;
    rd_state_t   rd_state, rd_next;

    logic [WIDTH-1:0] grade [NUM_CH];
    logic [NUM_CH-1:0] ovr;

    logic             t_in_range, p_permit, rd_in_range;
    logic             p_ok, t_ok, reject;
    logic [WIDTH-1:0] rd_sel_data;
    logic             rd_sel_ovr;
    logic [WIDTH-1:0] rd_data_q;
    logic             rd_ovr_q;

    // Channel decode by iteration keeps out-of-range indices from ever
    // addressing the register file or the permission mask.
    always_comb begin
        t_in_range  = 1'b0;
        p_permit    = 1'b0;
        rd_in_range = 1'b0;
        rd_sel_data = '0;
        rd_sel_ovr  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (t_wr_ch == CHW'(i)) t_in_range = 1'b1;
            if (p_wr_ch == CHW'(i)) p_permit = P_MASK[i];
            if (s_rd_ch == CHW'(i)) begin
                rd_in_range = 1'b1;
                rd_sel_data = grade[i];
                rd_sel_ovr  = ovr[i];
            end
        end
    end

    always_comb begin
        p_ok   = p_wr_en && p_permit;
        t_ok   = t_wr_en && (bank_state == OPEN) && t_in_range &&
                 !(p_ok && (p_wr_ch == t_wr_ch));
        reject = (t_wr_en && !t_ok) || (p_wr_en && !p_ok);
    end

    always_comb begin
        bank_next = bank_state;
        if (p_lock) bank_next = LOCKED;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) bank_state <= OPEN;
        else     bank_state <= bank_next;
    end

    assign locked = (bank_state == LOCKED);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) grade[i] <= '0;
            ovr    <= '0;
            wr_err <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (p_ok && (p_wr_ch == CHW'(i))) begin
                    grade[i] <= p_wr_data;
                    ovr[i]   <= 1'b1;
                end else if (t_ok && (t_wr_ch == CHW'(i))) begin
                    grade[i] <= t_wr_data;
                    ovr[i]   <= 1'b0;
                end
            end
            wr_err <= reject;
        end
    end

    // Read handshake: s_rd_valid is high in PRESENT; data and ovr hold
    // steady until the rising edge that sees s_rd_ready=1, which retires it.
    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            IDLE:    if (s_rd_req && rd_in_range) rd_next = PRESENT;
            PRESENT: if (s_rd_ready) rd_next = IDLE;
            default: rd_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_state <= IDLE;
        else     rd_state <= rd_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
            rd_ovr_q  <= 1'b0;
        end else if (rd_state == IDLE && rd_next == PRESENT) begin
            rd_data_q <= rd_sel_data;
            rd_ovr_q  <= rd_sel_ovr;
        end else if (rd_state == PRESENT && rd_next == IDLE) begin
            rd_data_q <= '0;
            rd_ovr_q  <= 1'b0;
        end
    end

    assign s_rd_valid = (rd_state == PRESENT);
    assign s_rd_data  = rd_data_q;
    assign s_rd_ovr   = rd_ovr_q;

endmodule
